// File: rtl/adder_arb_pkg.sv
// Shared types and widths for the round-robin adder arbiter.
//   OP_W   : operand width of the shared adder
//   RES_W  : result width returned by the adder
//   IDX_W  : width of a requester index (up to 8 requesters)
//   tag_t  : in-flight tag {vld, idx} travelling alongside the adder latency
package adder_arb_pkg;
   localparam int OP_W  = 4;
   localparam int RES_W = 7;
   localparam int IDX_W = 3;

   typedef logic [OP_W-1:0]  operand_t;
   typedef logic [RES_W-1:0] result_t;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : requester that currently has first priority
//   grant : one-hot grant (all zero when no request)
//   idx   : encoded index of the granted requester (0 when no request)
// The search order is ptr, ptr+1, ... wrapping modulo NUM_REQ.
module rr_picker
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   int                 pos;
   logic [NUM_REQ-1:0] req_sh;

   // Walk the offsets from the far end back to zero so the nearest
   // requester after ptr is the last one written and therefore wins.
   always_comb begin
      grant  = '0;
      idx    = '0;
      pos    = 0;
      req_sh = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         req_sh = req >> pos;
         if (req_sh[0]) begin
            grant = NUM_REQ'(1) << pos;
            idx   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   arb_en                : gates new grants; in-flight work still drains
//   req_valid/req_ready   : per-requester handshake
//   req_a/req_b           : packed operands, requester i at [4i+3:4i]
//   add_valid/add_a/add_b : operands issued to the adder
//   add_c                 : adder result, valid ADD_LAT cycles after add_valid
//   rsp_valid/rsp_c       : one-hot single-cycle result strobe and result
//   busy                  : any operation issued, in the adder, or responding
// Optional build macro ADDER_ARB_PRIO0_EN: requester 0 wins whenever it is
// valid and such wins leave the round-robin pointer untouched.
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arb_en,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*OP_W-1:0] req_a,
   input  logic [NUM_REQ*OP_W-1:0] req_b,
   output logic                    add_valid,
   output logic [OP_W-1:0]         add_a,
   output logic [OP_W-1:0]         add_b,
   input  logic [RES_W-1:0]        add_c,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [RES_W-1:0]        rsp_c,
   output logic                    busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] rr_grant;
   logic [IDX_W-1:0]   rr_idx;
   logic [NUM_REQ-1:0] gnt_vec;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   ptr_adv;
   logic               xfer;
   logic               ptr_upd;
   operand_t           sel_a;
   operand_t           sel_b;
   logic [IDX_W-1:0]   idx_p0;
   tag_t               tag_p1 [ADD_LAT];
   tag_t               tag_last;
   logic               tag_any;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

`ifdef ADDER_ARB_PRIO0_EN
   logic prio_win;

   assign prio_win = req_valid[0];
   assign gnt_vec  = prio_win ? NUM_REQ'(1) : rr_grant;
   assign gnt_idx  = prio_win ? '0 : rr_idx;
   assign ptr_upd  = xfer & ~prio_win;
`else
   assign gnt_vec  = rr_grant;
   assign gnt_idx  = rr_idx;
   assign ptr_upd  = xfer;
`endif

   assign req_ready = arb_en ? gnt_vec : '0;
   assign xfer      = |req_ready;
   assign ptr_adv   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_vec[i]) begin
            sel_a = req_a[i*OP_W +: OP_W];
            sel_b = req_b[i*OP_W +: OP_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (ptr_upd) begin
         ptr_q <= ptr_adv;
      end
   end

   // ---- stage p0: issue to adder ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         add_valid <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         idx_p0    <= '0;
      end else begin
         add_valid <= xfer;
         if (xfer) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            idx_p0 <= gnt_idx;
         end
      end
   end

   // ---- stage p1: tags shadowing the adder latency ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < ADD_LAT; k++) begin
            tag_p1[k] <= '0;
         end
      end else begin
         tag_p1[0] <= {add_valid, idx_p0};
         for (int k = 1; k < ADD_LAT; k++) begin
            tag_p1[k] <= tag_p1[k-1];
         end
      end
   end

   assign tag_last = tag_p1[ADD_LAT-1];

   always_comb begin
      tag_any = 1'b0;
      for (int k = 0; k < ADD_LAT; k++) begin
         tag_any = tag_any | tag_p1[k].vld;
      end
   end

   // ---- stage p2: response to the originating requester ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_c     <= '0;
      end else begin
         rsp_valid <= tag_last.vld ? (NUM_REQ'(1) << tag_last.idx) : '0;
         if (tag_last.vld) begin
            rsp_c <= add_c;
         end
      end
   end

   assign busy = add_valid | tag_any | (|rsp_valid);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Testbench for adder_rr_arbiter: models the external adder and keeps a
// transaction-level reference of grants, issue and responses.
module tb_adder_rr_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADD_LAT = 1;

   typedef struct {
      int acc;
      int idx;
      int a;
      int b;
   } op_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   arb_en = 1'b0;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*4-1:0]   req_a = '0;
   logic [NUM_REQ*4-1:0]   req_b = '0;
   logic                   add_valid;
   logic [3:0]             add_a;
   logic [3:0]             add_b;
   logic [6:0]             add_c;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [6:0]             rsp_c;
   logic                   busy;

   logic [6:0]             c_pipe [ADD_LAT];

   int                     checks = 0;
   int                     passes = 0;
   int                     mptr = 0;
   int                     cyc = 0;
   int                     hold_a = 0;
   int                     hold_b = 0;
   op_t                    q[$];
   logic [NUM_REQ-1:0]     exp_ready;
   logic                   exp_add_valid;
   logic [NUM_REQ-1:0]     exp_rsp_valid;
   int                     exp_rsp_c;
   logic                   exp_busy;

   always #5 clk = ~clk;

   adder_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADD_LAT (ADD_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .arb_en    (arb_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_valid (add_valid),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c     (add_c),
      .rsp_valid (rsp_valid),
      .rsp_c     (rsp_c),
      .busy      (busy)
   );

   // External adder: registered sum, ADD_LAT cycles deep.
   always @(posedge clk) begin
      c_pipe[0] <= {3'b000, add_a} + {3'b000, add_b};
      for (int k = 1; k < ADD_LAT; k++) c_pipe[k] <= c_pipe[k-1];
   end
   assign add_c = c_pipe[ADD_LAT-1];

   function automatic logic [NUM_REQ*4-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
      return {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
   endfunction

   task automatic model_reset();
      q.delete();
      mptr = 0;
      cyc = 0;
      hold_a = 0;
      hold_b = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      arb_en = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of stimulus and advance the reference model.
   task automatic run_cycle(input logic en, input logic [NUM_REQ-1:0] v,
                            input logic [NUM_REQ*4-1:0] a, input logic [NUM_REQ*4-1:0] b);
      logic [NUM_REQ*4-1:0] sh;
      logic [NUM_REQ-1:0]   vs;
      int                   gi;
      int                   p;
      op_t                  op;
      @(negedge clk);
      arb_en = en;
      req_valid = v;
      req_a = a;
      req_b = b;
      cyc++;
      exp_add_valid = 1'b0;
      exp_rsp_valid = '0;
      exp_rsp_c = 0;
      exp_busy = 1'b0;
      foreach (q[j]) begin
         if (cyc == q[j].acc + 1) begin
            exp_add_valid = 1'b1;
            hold_a = q[j].a;
            hold_b = q[j].b;
         end
         if (cyc == q[j].acc + ADD_LAT + 2) begin
            exp_rsp_valid = NUM_REQ'(1) << q[j].idx;
            exp_rsp_c = q[j].a + q[j].b;
         end
         if (cyc >= q[j].acc + 1 && cyc <= q[j].acc + ADD_LAT + 2) exp_busy = 1'b1;
      end
      while (q.size() > 0 && q[0].acc + ADD_LAT + 2 < cyc) void'(q.pop_front());
      exp_ready = '0;
      gi = -1;
      if (en) begin
`ifdef ADDER_ARB_PRIO0_EN
         if (v[0]) gi = 0;
`endif
         for (int k = 0; k < NUM_REQ; k++) begin
            p = (mptr + k) % NUM_REQ;
            vs = v >> p;
            if (gi < 0 && vs[0]) gi = p;
         end
      end
      if (gi >= 0) begin
         exp_ready = NUM_REQ'(1) << gi;
         sh = a >> (4 * gi);
         op.a = int'(sh[3:0]);
         sh = b >> (4 * gi);
         op.b = int'(sh[3:0]);
         op.acc = cyc;
         op.idx = gi;
         q.push_back(op);
`ifdef ADDER_ARB_PRIO0_EN
         if (gi != 0) mptr = (gi + 1) % NUM_REQ;
`else
         mptr = (gi + 1) % NUM_REQ;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (add_valid !== 1'b0) $display("FAIL rst_add_valid: got %b want 0", add_valid); else passes++;
      checks++; if (add_a !== 4'd0 || add_b !== 4'd0) $display("FAIL rst_add_ab: got %0d/%0d want 0/0", add_a, add_b); else passes++;
      checks++; if (rsp_valid !== '0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
      checks++; if (rsp_c !== 7'd0) $display("FAIL rst_rsp_c: got %0d want 0", rsp_c); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      // Accept req1 (3+4), then reset while it is in the adder.
      run_cycle(1'b1, 4'b0010, pack4(0, 3, 0, 0), pack4(0, 4, 0, 0));
      checks++; if (req_ready !== 4'b0010) $display("FAIL midrst_grant: got %b want 0010", req_ready); else passes++;
      run_cycle(1'b1, 4'b0000, '0, '0);
      checks++; if (add_valid !== 1'b1 || add_a !== 4'd3) $display("FAIL midrst_issue: got %b/%0d want 1/3", add_valid, add_a); else passes++;
      reset = 1'b1;
      #1;
      checks++; if (add_valid !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) $display("FAIL midrst_async: got v=%b busy=%b rsp=%b want 0/0/0", add_valid, busy, rsp_valid); else passes++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b1, 4'b0000, '0, '0);
         checks++; if (rsp_valid !== '0 || busy !== 1'b0) $display("FAIL midrst_no_rsp: got rsp=%b busy=%b want 0/0", rsp_valid, busy); else passes++;
      end
      run_cycle(1'b1, 4'b1111, '0, '0);
      checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr0: got %b want 0001", req_ready); else passes++;
      repeat (4) run_cycle(1'b1, 4'b0000, '0, '0);
   endtask

   task automatic test_single();
      run_cycle(1'b1, 4'b0100, pack4(0, 0, 9, 0), pack4(0, 0, 8, 0));
      checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready); else passes++;
      run_cycle(1'b1, 4'b0000, '0, '0);
      checks++; if (add_valid !== 1'b1 || add_a !== 4'd9 || add_b !== 4'd8) $display("FAIL single_issue: got %b %0d %0d want 1 9 8", add_valid, add_a, add_b); else passes++;
      run_cycle(1'b1, 4'b0000, '0, '0);
      checks++; if (rsp_valid !== '0) $display("FAIL single_early: got %b want 0", rsp_valid); else passes++;
      run_cycle(1'b1, 4'b0000, '0, '0);
      checks++; if (rsp_valid !== 4'b0100 || rsp_c !== 7'd17) $display("FAIL single_rsp: got %b %0d want 0100 17", rsp_valid, rsp_c); else passes++;
      run_cycle(1'b1, 4'b0000, '0, '0);
      checks++; if (rsp_valid !== '0 || add_a !== 4'd9) $display("FAIL single_strobe_hold: got %b %0d want 0 9", rsp_valid, add_a); else passes++;
   endtask

   task automatic test_all_valid();
      logic [NUM_REQ-1:0] want [5];
      want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i < 5) run_cycle(1'b1, 4'b1111, pack4(15, 1, 7, 10), pack4(15, 2, 6, 12));
         else run_cycle(1'b1, 4'b0000, '0, '0);
         if (i < 5) begin
            checks++; if (req_ready !== want[i]) $display("FAIL allv_grant%0d: got %b want %b", i, req_ready, want[i]); else passes++;
         end
         checks++; if (rsp_valid !== exp_rsp_valid) $display("FAIL allv_rsp%0d: got %b want %b", i, rsp_valid, exp_rsp_valid); else passes++;
         if (exp_rsp_valid != 0) begin
            checks++; if (rsp_c !== 7'(exp_rsp_c)) $display("FAIL allv_sum%0d: got %0d want %0d", i, rsp_c, exp_rsp_c); else passes++;
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run_cycle(1'b1, 4'b0100, '0, '0);
      run_cycle(1'b1, 4'b1001, pack4(1, 0, 0, 2), pack4(1, 0, 0, 2));
      checks++; if (req_ready !== 4'b1000) $display("FAIL wrap_g3: got %b want 1000", req_ready); else passes++;
      run_cycle(1'b1, 4'b1001, pack4(1, 0, 0, 2), pack4(1, 0, 0, 2));
      checks++; if (req_ready !== 4'b0001) $display("FAIL wrap_g0: got %b want 0001", req_ready); else passes++;
      run_cycle(1'b1, 4'b1011, '0, '0);
      checks++; if (req_ready !== 4'b0010) $display("FAIL wrap_ptr1: got %b want 0010", req_ready); else passes++;
      repeat (4) run_cycle(1'b1, 4'b0000, '0, '0);
   endtask

   task automatic test_arb_en();
      run_cycle(1'b1, 4'b0001, pack4(5, 0, 0, 0), pack4(6, 0, 0, 0));
      checks++; if (req_ready !== 4'b0001) $display("FAIL arben_first: got %b want 0001", req_ready); else passes++;
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b0, 4'b0001, pack4(5, 0, 0, 0), pack4(6, 0, 0, 0));
         checks++; if (req_ready !== '0) $display("FAIL arben_off_ready%0d: got %b want 0", i, req_ready); else passes++;
         checks++; if (busy !== exp_busy) $display("FAIL arben_busy%0d: got %b want %b", i, busy, exp_busy); else passes++;
      end
      checks++; if (busy !== 1'b0) $display("FAIL arben_drained: got %b want 0", busy); else passes++;
      run_cycle(1'b1, 4'b0001, pack4(5, 0, 0, 0), pack4(6, 0, 0, 0));
      checks++; if (req_ready !== 4'b0001) $display("FAIL arben_reenable: got %b want 0001", req_ready); else passes++;
      repeat (4) run_cycle(1'b1, 4'b0000, '0, '0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         run_cycle(1'($urandom_range(0, 7) != 0), NUM_REQ'($urandom), NUM_REQ*4'($urandom), NUM_REQ*4'($urandom));
         checks++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, exp_ready); else passes++;
         checks++; if (add_valid !== exp_add_valid || add_a !== 4'(hold_a) || add_b !== 4'(hold_b))
            $display("FAIL rnd_issue c%0d: got %b %0d %0d want %b %0d %0d", cyc, add_valid, add_a, add_b, exp_add_valid, hold_a, hold_b); else passes++;
         checks++; if (rsp_valid !== exp_rsp_valid) $display("FAIL rnd_rsp c%0d: got %b want %b", cyc, rsp_valid, exp_rsp_valid); else passes++;
         if (exp_rsp_valid != 0) begin
            checks++; if (rsp_c !== 7'(exp_rsp_c)) $display("FAIL rnd_sum c%0d: got %0d want %0d", cyc, rsp_c, exp_rsp_c); else passes++;
         end
         checks++; if (busy !== exp_busy) $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, exp_busy); else passes++;
      end
      repeat (4) run_cycle(1'b1, 4'b0000, '0, '0);
   endtask

`ifdef ADDER_ARB_PRIO0_EN
   task automatic test_prio0();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 4'b0011, pack4(1, 2, 0, 0), pack4(1, 2, 0, 0));
         checks++; if (req_ready !== 4'b0001) $display("FAIL prio_win%0d: got %b want 0001", i, req_ready); else passes++;
      end
      run_cycle(1'b1, 4'b0010, pack4(1, 2, 0, 0), pack4(1, 2, 0, 0));
      checks++; if (req_ready !== 4'b0010) $display("FAIL prio_req1: got %b want 0010", req_ready); else passes++;
      run_cycle(1'b1, 4'b0110, '0, '0);
      checks++; if (req_ready !== 4'b0100) $display("FAIL prio_ptr: got %b want 0100", req_ready); else passes++;
      repeat (4) run_cycle(1'b1, 4'b0000, '0, '0);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
`ifdef ADDER_ARB_PRIO0_EN
      test_prio0();
`else
      test_all_valid();
      test_wrap();
`endif
      test_arb_en();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
